// File: rtl/serial_word_receiver.sv
// Deserializes a framed serial bit stream (MSB- or LSB-first) into WIDTH-bit words
// presented on a valid/ready output register, with a sticky flag for dropped words.
module serial_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Dir,
  input  logic             Sin,
  input  logic             Sin_vld,
  output logic [WIDTH-1:0] DataOut,
  output logic             Out_vld,
  input  logic             Out_rdy,
  output logic             Busy,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sr_r, sr_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             dir_r, dir_s;
  logic [WIDTH-1:0] dout_r, dout_s;
  logic             vld_r, vld_s;
  logic             ovf_r, ovf_s;

  logic             done_s;
  logic             shift_dir_s;
  logic [CW-1:0]    base_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] word_s;

  // State, shift and output registers; reset overrides everything, including a live frame.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_r <= ST_IDLE;
      sr_r    <= {WIDTH{1'b0}};
      cnt_r   <= ZERO_CNT;
      dir_r   <= 1'b0;
      dout_r  <= {WIDTH{1'b0}};
      vld_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      sr_r    <= sr_s;
      cnt_r   <= cnt_s;
      dir_r   <= dir_s;
      dout_r  <= dout_s;
      vld_r   <= vld_s;
      ovf_r   <= ovf_s;
    end
  end

  // Next-state: frame start/abort, bit capture, completion and output handshake.
  always_comb begin
    state_s     = state_r;
    sr_s        = sr_r;
    cnt_s       = cnt_r;
    dir_s       = dir_r;
    dout_s      = dout_r;
    vld_s       = vld_r;
    ovf_s       = ovf_r;
    done_s      = 1'b0;
    word_s      = sr_r;
    shift_dir_s = dir_r;
    base_s      = cnt_r;

    // Start (in either state) restarts the frame; a coincident bit becomes bit 0.
    if (Start) begin
      state_s     = ST_SHIFT;
      dir_s       = Dir;
      cnt_s       = ZERO_CNT;
      shift_dir_s = Dir;
      base_s      = ZERO_CNT;
    end else begin
      shift_dir_s = dir_r;
      base_s      = cnt_r;
    end

    shifted_s = shift_dir_s ? {Sin, sr_r[WIDTH-1:1]} : {sr_r[WIDTH-2:0], Sin};

    if (Sin_vld && (Start || (state_r == ST_SHIFT))) begin
      sr_s = shifted_s;
      if (base_s == LAST_CNT) begin
        done_s  = 1'b1;
        word_s  = shifted_s;
        state_s = ST_IDLE;
        cnt_s   = ZERO_CNT;
      end else begin
        cnt_s = base_s + CW'(1);
      end
    end else begin
      done_s = 1'b0;
    end

    // A completing word loads only if the register is empty or being drained this cycle.
    if (done_s) begin
      if (!vld_r || Out_rdy) begin
        dout_s = word_s;
        vld_s  = 1'b1;
      end else begin
        ovf_s = 1'b1;
      end
    end else if (vld_r && Out_rdy) begin
      vld_s = 1'b0;
    end else begin
      vld_s = vld_r;
    end
  end

  assign DataOut = dout_r;
  assign Out_vld = vld_r;
  assign Busy    = (state_r == ST_SHIFT);
  assign Ovf     = ovf_r;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed and randomized checks of serial_word_receiver against a queue-based
// frame model that assembles words from the list of received bits.
module tb_serial_word_receiver;

  localparam int W = 4;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Start = 1'b0;
  logic         Dir = 1'b0;
  logic         Sin = 1'b0;
  logic         Sin_vld = 1'b0;
  logic         Out_rdy = 1'b0;
  logic [W-1:0] DataOut;
  logic         Out_vld;
  logic         Busy;
  logic         Ovf;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit           m_bits[$];
  bit           m_active = 1'b0;
  bit           m_dir = 1'b0;
  logic [W-1:0] m_dout = '0;
  bit           m_vld = 1'b0;
  bit           m_ovf = 1'b0;

  serial_word_receiver #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .Dir     (Dir),
    .Sin     (Sin),
    .Sin_vld (Sin_vld),
    .DataOut (DataOut),
    .Out_vld (Out_vld),
    .Out_rdy (Out_rdy),
    .Busy    (Busy),
    .Ovf     (Ovf)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: collect bits, build the word by bit position once W have arrived.
  task automatic model_update();
    bit           done;
    logic [W-1:0] word;
    done = 1'b0;
    word = '0;
    if (!Rst) begin
      m_bits.delete();
      m_active = 1'b0;
      m_dir    = 1'b0;
      m_dout   = '0;
      m_vld    = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      if (Start) begin
        m_active = 1'b1;
        m_dir    = Dir;
        m_bits.delete();
      end
      if (Sin_vld && m_active) begin
        m_bits.push_back(Sin);
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            if (m_dir) word[i] = m_bits[i];
            else       word[W-1-i] = m_bits[i];
          end
          done = 1'b1;
          m_bits.delete();
          m_active = 1'b0;
        end
      end
      if (done) begin
        if (!m_vld || Out_rdy) begin
          m_dout = word;
          m_vld  = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_vld && Out_rdy) begin
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge Clk);
    model_update();
    #1;
    chk({tag, ".dout"}, 32'(DataOut), 32'(m_dout));
    chk({tag, ".vld"},  32'(Out_vld), 32'(m_vld));
    chk({tag, ".busy"}, 32'(Busy),    32'(m_active));
    chk({tag, ".ovf"},  32'(Ovf),     32'(m_ovf));
  endtask

  task automatic cyc(input string tag, input logic rst, input logic st, input logic d,
                     input logic s, input logic v, input logic r);
    Rst = rst; Start = st; Dir = d; Sin = s; Sin_vld = v; Out_rdy = r;
    step(tag);
  endtask

  initial begin
    // T1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      cyc("t1", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    chk("t1.dout0", 32'(DataOut), 32'h0);
    chk("t1.vld0",  32'(Out_vld), 32'h0);
    chk("t1.busy0", 32'(Busy),    32'h0);
    chk("t1.ovf0",  32'(Ovf),     32'h0);

    // T2: MSB first, consecutive bits 1,0,1,1
    cyc("t2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("t2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("t2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("t2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t2.word", 32'(DataOut), 32'hB);
    chk("t2.vld",  32'(Out_vld), 32'h1);
    cyc("t2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2.vlddrop", 32'(Out_vld), 32'h0);

    // T3: LSB first with idle gaps
    cyc("t3", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc("t3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3.busygap", 32'(Busy), 32'h1);
    cyc("t3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("t3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("t3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("t3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t3.busygap2", 32'(Busy), 32'h1);
    cyc("t3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t3.word", 32'(DataOut), 32'hD);
    chk("t3.busyend", 32'(Busy), 32'h0);
    cyc("t3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // T4: backpressure, 4'hA then 4'h5 dropped
    cyc("t4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4.wordA", 32'(DataOut), 32'hA);
    cyc("t4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4.held", 32'(DataOut), 32'hA);
    chk("t4.ovf",  32'(Ovf),     32'h1);
    chk("t4.vld",  32'(Out_vld), 32'h1);
    cyc("t4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4.vlddrop", 32'(Out_vld), 32'h0);
    chk("t4.ovfhold", 32'(Ovf),     32'h1);

    // T5: abort then 0,1,1,0 MSB first
    cyc("t5", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc("t5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("t5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("t5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("t5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5.noword", 32'(Out_vld), 32'h0);
    cyc("t5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5.word", 32'(DataOut), 32'h6);
    cyc("t5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // reset mid-frame
    cyc("t5r", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("t5r", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("t5r", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5r.busy", 32'(Busy), 32'h0);
    chk("t5r.ovf",  32'(Ovf),  32'h0);
    cyc("t5r", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("t5r", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5r.noword", 32'(Out_vld), 32'h0);

    // T6: transfer of word 1 coincides with completion of word 2
    cyc("t6", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t6", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t6", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6.word1", 32'(DataOut), 32'h3);
    cyc("t6", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t6", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("t6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("t6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6.word2", 32'(DataOut), 32'hC);
    chk("t6.vld",   32'(Out_vld), 32'h1);
    chk("t6.ovf",   32'(Ovf),     32'h0);
    cyc("t6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc("rnd",
          ($urandom_range(0, 63) != 0),
          ($urandom_range(0, 7) == 0),
          1'($urandom),
          1'($urandom),
          1'($urandom),
          1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
